cartoon_filter: RTL and testbench

Pixel-processing stage directly downstream of the read buffer. Accepts one 3x3 window of 24-bit RGB pixels per handshake. Computes a Gaussian-blurred, posterized centre pixel, or forces it to black when a Sobel edge is detected. Emits the result toward the write-back path, returns a per-window `pixel_done` pulse to the read buffer, and flags frame completion.

---
 rtl/cartoon_filter.sv | 119 +++++++++++
 tb/tb_cartoon_filter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cartoon_filter.sv
`default_nettype none
// ============================================================================
// Module  : cartoon_filter
// Brief   : 3x3 Gaussian blur + posterize of the centre pixel, forced black on
//           a Sobel edge; 3-stage pipeline with global stall and frame counter.
// Rev     : 1.0  initial release
// ============================================================================
module cartoon_filter #(
  parameter logic [10:0] EDGE_THRESH  = 11'd200,
  parameter int          QUANT_BITS   = 2,
  parameter int          FRAME_PIXELS = 307200
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [215:0] window_in,
  input  logic         window_valid,
  output logic         window_ready,
  output logic [23:0]  pixel_out,
  output logic         pixel_valid,
  input  logic         pixel_ready,
  output logic         pixel_done,
  output logic         frame_done
);

  localparam int                 c_CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(FRAME_PIXELS - 1);
  localparam logic [7:0]         c_QMASK = 8'(8'hFF << QUANT_BITS);
  // log2 of the 1-2-1 / 2-4-2 / 1-2-1 Gaussian weights, row-major
  localparam int                 c_SH [9] = '{0, 1, 0, 1, 2, 1, 0, 1, 0};

  logic               r_v1, r_v2, r_v3;
  logic [11:0]        r_sum  [3];
  logic [7:0]         r_luma [9];
  logic               r_edge;
  logic [23:0]        r_blur;
  logic [23:0]        r_pix;
  logic               r_pdone, r_fdone;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_adv, w_accept, w_xfer;
  logic [11:0]        w_sum  [3];
  logic [7:0]         w_luma [9];
  logic [10:0]        w_gx, w_gy, w_mag;
  logic               w_edge;
  logic [23:0]        w_blur;

  function automatic logic [10:0] col3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  function automatic logic [10:0] abs11(input logic [10:0] x);
    return x[10] ? (~x + 11'd1) : x;
  endfunction

  assign w_adv        = !r_v3 || pixel_ready;
  assign w_accept     = window_valid && w_adv;
  assign w_xfer       = r_v3 && pixel_ready;
  assign window_ready = w_adv;

  always_comb begin : p_s1
    logic [23:0] px;
    px = '0;
    for (int c = 0; c < 3; c++) w_sum[c] = '0;
    for (int k = 0; k < 9; k++) begin
      px        = window_in[215-24*k -: 24];
      w_luma[k] = 8'(({2'b00, px[23:16]} + {1'b0, px[15:8], 1'b0} + {2'b00, px[7:0]}) >> 2);
      for (int c = 0; c < 3; c++)
        w_sum[c] = w_sum[c] + ({4'b0000, px[23-8*c -: 8]} << c_SH[k]);
    end
  end

  // Gradients are formed modulo 2^11, which holds the full +/-1020 range
  always_comb begin : p_s2
    w_gx   = col3(r_luma[2], r_luma[5], r_luma[8]) - col3(r_luma[0], r_luma[3], r_luma[6]);
    w_gy   = col3(r_luma[6], r_luma[7], r_luma[8]) - col3(r_luma[0], r_luma[1], r_luma[2]);
    w_mag  = abs11(w_gx) + abs11(w_gy);
    w_edge = w_mag > EDGE_THRESH;
    w_blur = {r_sum[0][11:4] & c_QMASK, r_sum[1][11:4] & c_QMASK, r_sum[2][11:4] & c_QMASK};
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_edge  <= 1'b0;
      r_blur  <= '0;
      r_pix   <= '0;
      r_pdone <= 1'b0;
      r_fdone <= 1'b0;
      r_cnt   <= '0;
      for (int c = 0; c < 3; c++) r_sum[c]  <= '0;
      for (int k = 0; k < 9; k++) r_luma[k] <= '0;
    end else begin
      r_pdone <= w_accept;
      r_fdone <= w_xfer && (r_cnt == c_LAST);
      if (w_xfer)
        r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
      if (w_adv) begin
        r_v1   <= w_accept;
        r_v2   <= r_v1;
        r_v3   <= r_v2;
        r_edge <= w_edge;
        r_blur <= w_blur;
        r_pix  <= r_edge ? 24'h000000 : r_blur;
        for (int c = 0; c < 3; c++) r_sum[c]  <= w_sum[c];
        for (int k = 0; k < 9; k++) r_luma[k] <= w_luma[k];
      end
    end
  end

  assign pixel_out   = r_pix;
  assign pixel_valid = r_v3;
  assign pixel_done  = r_pdone;
  assign frame_done  = r_fdone;

endmodule
`default_nettype wire

// File: tb/tb_cartoon_filter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cartoon_filter
// Brief   : Randomized and directed bench for cartoon_filter with a scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cartoon_filter;

  localparam int c_FP = 4;
  localparam int c_QB = 2;
  localparam int c_TH = 200;
  localparam int c_WT [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  typedef struct {
    logic [23:0] pix;
    int          age;
  } item_t;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [215:0] window_in;
  logic         window_valid;
  logic         window_ready;
  logic [23:0]  pixel_out;
  logic         pixel_valid;
  logic         pixel_ready;
  logic         pixel_done;
  logic         frame_done;

  int    n_checks = 0;
  int    n_errors = 0;
  item_t q[$];
  bit    armed    = 1'b0;
  bit    post_rst = 1'b0;
  bit    m_pdone  = 1'b0;
  bit    m_fdone  = 1'b0;
  int    m_hs     = 0;
  int    pd_cnt   = 0;

  always #5 clk = ~clk;

  cartoon_filter #(
    .EDGE_THRESH (11'd200),
    .QUANT_BITS  (c_QB),
    .FRAME_PIXELS(c_FP)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .window_in   (window_in),
    .window_valid(window_valid),
    .window_ready(window_ready),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_done  (pixel_done),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected output pixel straight from the filter equations
  function automatic logic [23:0] ref_pixel(input logic [215:0] w);
    int p [9][3];
    int y [9];
    int s, b, gx, gy, mag;
    logic [23:0] r;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 3; c++)
        p[k][c] = int'(32'((w >> (208 - 24*k - 8*c)) & 216'hFF));
      y[k] = (p[k][0] + 2*p[k][1] + p[k][2]) / 4;
    end
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = 0;
      for (int k = 0; k < 9; k++) s += c_WT[k] * p[k][c];
      b = (s / 16) & (255 - ((1 << c_QB) - 1));
      r[23-8*c -: 8] = 8'(b);
    end
    gx  = (y[2] + 2*y[5] + y[8]) - (y[0] + 2*y[3] + y[6]);
    gy  = (y[6] + 2*y[7] + y[8]) - (y[0] + 2*y[1] + y[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > c_TH) ? 24'h000000 : r;
  endfunction

  function automatic logic [215:0] rnd_win();
    logic [215:0] w;
    logic [23:0]  base;
    bit           smooth;
    smooth = ($urandom_range(0, 1) == 1);
    base   = 24'($urandom);
    w      = '0;
    for (int k = 0; k < 9; k++) begin
      if (smooth)
        w[215-24*k -: 24] = {base[23:16] ^ 8'($urandom_range(0, 3)),
                             base[15:8]  ^ 8'($urandom_range(0, 3)),
                             base[7:0]   ^ 8'($urandom_range(0, 3))};
      else
        w[215-24*k -: 24] = 24'($urandom);
    end
    return w;
  endfunction

  // Scoreboard: each accepted window ages one stage per advancing edge
  always @(negedge clk) begin : p_mon
    bit mv, madv, acc, hs;
    mv   = (q.size() > 0) && (q[0].age == 3);
    madv = !mv || pixel_ready;
    if (armed) begin
      check("pixel_valid", {31'd0, pixel_valid}, {31'd0, mv});
      check("window_ready", {31'd0, window_ready}, {31'd0, madv});
      check("pixel_done", {31'd0, pixel_done}, {31'd0, m_pdone});
      check("frame_done", {31'd0, frame_done}, {31'd0, m_fdone});
      if (mv) check("pixel_out", {8'd0, pixel_out}, {8'd0, q[0].pix});
      if (post_rst) check("rst_pixel_out", {8'd0, pixel_out}, 32'd0);
    end
    if (pixel_done) pd_cnt++;
    post_rst = 1'b0;
    if (n_rst) begin
      q.delete();
      m_pdone  = 1'b0;
      m_fdone  = 1'b0;
      m_hs     = 0;
      armed    = 1'b1;
      post_rst = 1'b1;
    end else begin
      acc     = window_valid && madv;
      hs      = mv && pixel_ready;
      m_fdone = hs && ((m_hs % c_FP) == c_FP - 1);
      if (hs) begin
        m_hs++;
        void'(q.pop_front());
      end
      if (madv) foreach (q[i]) q[i].age++;
      if (acc) q.push_back('{ref_pixel(window_in), 1});
      m_pdone = acc;
    end
  end

  task automatic send(input logic [215:0] w);
    int n;
    n            = 0;
    window_in    = w;
    window_valid = 1'b1;
    @(negedge clk);
    while (!window_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    window_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [23:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!(pixel_valid && pixel_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_timeout"}, 32'd1, 32'd0);
    else         check(tag, {8'd0, pixel_out}, {8'd0, exp});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [215:0] fill(input logic [23:0] a, input logic [23:0] b,
                                        input logic [8:0] sel_b);
    logic [215:0] w;
    for (int k = 0; k < 9; k++) w[215-24*k -: 24] = sel_b[k] ? b : a;
    return w;
  endfunction

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    logic [215:0] sw [10];
    int           pd0;
    bit           done;
    n_rst        = 1'b1;
    window_valid = 1'b0;
    window_in    = '0;
    pixel_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;

    send(fill(24'h808080, 24'h808080, 9'h000));
    expect_out("uniform", 24'h808080);
    send(fill(24'hFFFFFF, 24'h000000, 9'b001001001));
    expect_out("left_edge", 24'h000000);
    send(fill(24'h000000, 24'h100000, 9'b000010000));
    expect_out("impulse", 24'h040000);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) sw[i] = rnd_win();
    pd0 = pd_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) send(sw[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 pixel_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 pixel_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("stream_pixel_done_count", 32'(pd_cnt - pd0), 32'd10);

    pixel_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_win());
    n_rst = 1'b1;
    @(posedge clk);
    #1 n_rst = 1'b0;
    pixel_ready = 1'b1;
    send(fill(24'h000000, 24'h100000, 9'b000010000));
    expect_out("post_reset", 24'h040000);

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rnd_win());
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          pixel_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        pixel_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
